conv_tap_mac: RTL

- Streaming convolution MAC that sits directly downstream of the pixel tap shift register.
- Each cycle it consumes the N parallel B-bit taps of the current window and multiplies tap i by signed coefficient i.
- It sums the products, then rounds, shifts and saturates the result back to a B-bit pixel.
- Coefficients are double-buffered: a shadow bank is loaded from the control side and committed atomically to the active bank.

---
 rtl/conv_tap_mac_pkg.sv | 29 ++
 rtl/conv_tap_mac_if.sv | 35 +++
 rtl/conv_tap_mac_round_sat.sv | 44 ++++
 rtl/conv_tap_mac.sv | 122 ++++++++++++
 4 files changed

// File: rtl/conv_tap_mac_pkg.sv
// conv_pkg: shared helpers for the convolution tap MAC and later 2-D stages.
//   prod_w     - width of one signed tap x coefficient product
//   acc_w      - width of the product sum (headroom for N products)
//   ident_coef - centre-tap coefficient of the identity kernel
//   round_bias - round-half-up bias added before the fixed-point shift
package conv_pkg;

    function automatic int prod_w(input int b, input int cw);
        return b + cw + 1;
    endfunction

    function automatic int acc_w(input int b, input int cw, input int n);
        return b + cw + 1 + $clog2(n);
    endfunction

    // 1.0 in the fixed-point scale, clipped to the largest positive coefficient.
    function automatic longint ident_coef(input int cw, input int shift);
        longint one_q;
        longint max_q;
        one_q = longint'(1) << shift;
        max_q = (longint'(1) << (cw - 1)) - 1;
        return (one_q > max_q) ? max_q : one_q;
    endfunction

    function automatic longint round_bias(input int shift);
        return (shift == 0) ? longint'(0) : (longint'(1) << (shift - 1));
    endfunction

endpackage

// File: rtl/conv_tap_mac_if.sv
// conv_tap_mac_if: streaming tap input, coefficient control and pixel output.
//   in_valid    - taps valid this cycle
//   taps[N]     - unsigned window pixels, taps[0] newest
//   frame_start - restart window fill tracking
//   coef_wr/coef_idx/coef_data - shadow coefficient bank write
//   coef_commit - copy shadow bank to active bank
//   dout/dout_valid - result pixel
// master = upstream integrator, slave = MAC.
interface conv_tap_mac_if
    import conv_pkg::*;
#(
    parameter int N  = 11,
    parameter int B  = 8,
    parameter int CW = 8
);
    logic                    in_valid;
    logic [B-1:0]            taps [N];
    logic                    frame_start;
    logic                    coef_wr;
    logic [$clog2(N)-1:0]    coef_idx;
    logic signed [CW-1:0]    coef_data;
    logic                    coef_commit;
    logic [B-1:0]            dout;
    logic                    dout_valid;

    modport master (
        output in_valid, taps, frame_start, coef_wr, coef_idx, coef_data, coef_commit,
        input  dout, dout_valid
    );

    modport slave (
        input  in_valid, taps, frame_start, coef_wr, coef_idx, coef_data, coef_commit,
        output dout, dout_valid
    );
endinterface

// File: rtl/conv_tap_mac_round_sat.sv
// conv_round_sat: combinational round-half-up, arithmetic shift and clamp of
// a signed accumulator to an unsigned B-bit pixel.
//   sum_i - signed accumulator (AW bits)
//   pix_o - clamped pixel (B bits)
// Optional macro CONV_TAP_MAC_ABS_OUT_EN: negative results map to their
// magnitude (edge-detect kernels) instead of clamping to 0.
module conv_round_sat
    import conv_pkg::*;
#(
    parameter int B     = 8,
    parameter int AW    = 21,
    parameter int SHIFT = 7
) (
    input  logic signed [AW-1:0] sum_i,
    output logic        [B-1:0]  pix_o
);
    // One extra bit so adding the bias can never wrap.
    localparam int RW = AW + 1;
    localparam logic signed [RW-1:0] BIAS    = RW'(round_bias(SHIFT));
    localparam logic signed [RW-1:0] PIX_MAX = RW'((longint'(1) << B) - 1);

    function automatic logic signed [RW-1:0] round_shift(input logic signed [AW-1:0] s);
        return (RW'(s) + BIAS) >>> SHIFT;
    endfunction

    function automatic logic [B-1:0] sat_pix(input logic signed [RW-1:0] v);
        if (v < 0)            return '0;
        else if (v > PIX_MAX) return '1;
        else                  return v[B-1:0];
    endfunction

    logic signed [RW-1:0] r;
    logic signed [RW-1:0] mag;

    always_comb begin
        r = round_shift(sum_i);
`ifdef CONV_TAP_MAC_ABS_OUT_EN
        mag = (r < 0) ? -r : r;
`else
        mag = r;
`endif
        pix_o = sat_pix(mag);
    end
endmodule

// File: rtl/conv_tap_mac.sv
// conv_tap_mac: streaming N-tap convolution MAC behind the pixel shift register.
// Three register stages (multiply, sum, round/saturate), one sample per cycle.
// Coefficients are double-buffered: shadow bank written by coef_wr, copied
// atomically to the active bank by coef_commit.
//   clk, rst - clock, synchronous active-high reset
//   bus      - conv_tap_mac_if slave (taps in, coefficient control, dout out)
// Optional macro CONV_TAP_MAC_ABS_OUT_EN (in conv_round_sat): output |r|.
module conv_tap_mac
    import conv_pkg::*;
#(
    parameter int N     = 11,
    parameter int B     = 8,
    parameter int CW    = 8,
    parameter int SHIFT = 7
) (
    input  logic               clk,
    input  logic               rst,
    conv_tap_mac_if.slave      bus
);
    localparam int PW    = prod_w(B, CW);
    localparam int AW    = acc_w(B, CW, N);
    localparam int CNT_W = $clog2(N + 2);
    localparam logic signed [CW-1:0] ID_COEF = CW'(ident_coef(CW, SHIFT));

    logic signed [CW-1:0] shadow_q [N];
    logic signed [CW-1:0] active_q [N];

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 vld_p0;
    logic signed [PW-1:0] prod_p1_q [N];
    logic                 vld_p1_q;
    logic signed [AW-1:0] sum_d, sum_p2_q;
    logic                 vld_p2_q;
    logic [B-1:0]         pix_p3;
    logic [B-1:0]         dout_q;
    logic                 dout_valid_q;

    // Commit copies the shadow value from before any same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                shadow_q[i] <= (i == N / 2) ? ID_COEF : '0;
                active_q[i] <= (i == N / 2) ? ID_COEF : '0;
            end
        end else begin
            if (bus.coef_commit)
                active_q <= shadow_q;
            if (bus.coef_wr && (int'(bus.coef_idx) < N))
                shadow_q[bus.coef_idx] <= bus.coef_data;
        end
    end

    // Window fill: a sample is valid only once N samples of this frame exist.
    always_comb begin
        logic [CNT_W-1:0] base;
        logic [CNT_W-1:0] inc;
        base   = bus.frame_start ? '0 : cnt_q;
        inc    = base + CNT_W'(1);
        cnt_d  = base;
        vld_p0 = 1'b0;
        if (bus.in_valid) begin
            cnt_d  = (inc > CNT_W'(N)) ? CNT_W'(N) : inc;
            vld_p0 = (inc >= CNT_W'(N));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // ---- stage p1: per-tap signed products ----
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++)
            prod_p1_q[i] <= PW'($signed({1'b0, bus.taps[i]})) * PW'(active_q[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) vld_p1_q <= 1'b0;
        else     vld_p1_q <= vld_p0;
    end

    // ---- stage p2: sum of products ----
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N; i++)
            sum_d = sum_d + AW'(prod_p1_q[i]);
    end

    always_ff @(posedge clk) begin
        sum_p2_q <= sum_d;
    end

    always_ff @(posedge clk) begin
        if (rst) vld_p2_q <= 1'b0;
        else     vld_p2_q <= vld_p1_q;
    end

    // ---- stage p3: round, shift, saturate; dout holds between valid samples ----
    conv_round_sat #(
        .B     (B),
        .AW    (AW),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .sum_i (sum_p2_q),
        .pix_o (pix_p3)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= vld_p2_q;
            if (vld_p2_q)
                dout_q <= pix_p3;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
endmodule
